// File: rtl/conv_acc_scheduler.sv
// Sequencer between the feature stream, weight buffer and MAC core of the conv accelerator.
// Optional CONV_SCHED_PERF_CNT_EN adds the stall_cnt performance counter output.
module conv_acc_scheduler #(
  parameter int MAC_OUT_NUM   = 18,
  parameter int MAC_IN_NUM    = 9,
  parameter int DATA_WIDTH    = 8,
  parameter int PIX_CNT_WIDTH = 16
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               start,
  input  logic                               abort,
  input  logic [7:0]                         cfg_acc_num,
  input  logic [PIX_CNT_WIDTH-1:0]           cfg_pix_num,
  output logic                               wt_req,
  input  logic                               wt_ack,
  input  logic [MAC_IN_NUM*DATA_WIDTH-1:0]   in_data,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [MAC_IN_NUM*DATA_WIDTH-1:0]   mac_data,
  output logic                               mac_data_valid,
  output logic                               mac_weight_valid,
  output logic [MAC_OUT_NUM-1:0]             adder_rst,
  input  logic                               mac_out_valid,
  output logic                               busy,
  output logic                               done
`ifdef CONV_SCHED_PERF_CNT_EN
  ,
  output logic [31:0]                        stall_cnt
`endif
);

  localparam int BEAT_W = MAC_IN_NUM * DATA_WIDTH;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_W = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]               state;
  logic [2:0]               state_nxt;
  logic [7:0]               acc_num_q;
  logic [PIX_CNT_WIDTH-1:0] pix_num_q;
  logic [7:0]               beat_cnt;
  logic [PIX_CNT_WIDTH-1:0] pix_cnt;
  logic [PIX_CNT_WIDTH-1:0] out_cnt;
  logic [PIX_CNT_WIDTH-1:0] out_cnt_nxt;

  logic                     start_ok;
  logic                     accept;
  logic                     last_beat;
  logic                     last_pix;

  logic [BEAT_W-1:0]        mac_data_p1;
  logic                     vld_p1;
  logic                     wt_vld_p1;
  logic [MAC_OUT_NUM-1:0]   adder_rst_p1;

  assign start_ok  = (state == S_IDLE) && start && !abort;
  // abort is folded into in_ready so a cancelled cycle never shows a completed handshake
  assign in_ready  = (state == S_RUN) && !abort;
  assign accept    = in_valid && in_ready;
  assign last_beat = (beat_cnt == (acc_num_q - 8'd1));
  assign last_pix  = (pix_cnt == (pix_num_q - PIX_CNT_WIDTH'(1)));

  assign out_cnt_nxt = (mac_out_valid && (state != S_IDLE)) ? out_cnt + PIX_CNT_WIDTH'(1) : out_cnt;

  assign wt_req = (state == S_LOAD_W);
  assign busy   = (state != S_IDLE);
  assign done   = (state == S_DONE) && !abort;

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (start) state_nxt = (cfg_pix_num == '0) ? S_DONE : S_LOAD_W;
        S_LOAD_W: if (wt_ack) state_nxt = S_RUN;
        S_RUN:    if (accept && last_beat && last_pix) state_nxt = S_DRAIN;
        S_DRAIN:  if (out_cnt_nxt >= pix_num_q) state_nxt = S_DONE;
        S_DONE:   state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      acc_num_q <= 8'd1;
      pix_num_q <= '0;
      beat_cnt  <= '0;
      pix_cnt   <= '0;
      out_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (abort) begin
        beat_cnt <= '0;
        pix_cnt  <= '0;
        out_cnt  <= '0;
      end else if (start_ok) begin
        acc_num_q <= (cfg_acc_num == 8'd0) ? 8'd1 : cfg_acc_num;
        pix_num_q <= cfg_pix_num;
        beat_cnt  <= '0;
        pix_cnt   <= '0;
        out_cnt   <= '0;
      end else begin
        if (accept) begin
          if (last_beat) begin
            beat_cnt <= '0;
            pix_cnt  <= pix_cnt + PIX_CNT_WIDTH'(1);
          end else begin
            beat_cnt <= beat_cnt + 8'd1;
          end
        end
        out_cnt <= out_cnt_nxt;
      end
    end
  end

  // stage p1: accepted beat and its strobes registered toward the MAC core
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mac_data_p1  <= '0;
      vld_p1       <= 1'b0;
      wt_vld_p1    <= 1'b0;
      adder_rst_p1 <= '0;
    end else begin
      vld_p1       <= accept;
      wt_vld_p1    <= (state == S_LOAD_W) && wt_ack && !abort;
      adder_rst_p1 <= (accept && (beat_cnt == 8'd0)) ? '1 : '0;
      if (accept) mac_data_p1 <= in_data;
    end
  end

  assign mac_data         = mac_data_p1;
  assign mac_data_valid   = vld_p1;
  assign mac_weight_valid = wt_vld_p1;
  assign adder_rst        = adder_rst_p1;

`ifdef CONV_SCHED_PERF_CNT_EN
  // saturating count of RUN cycles where the scheduler waited on the feature source
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= '0;
    end else if (start_ok) begin
      stall_cnt <= '0;
    end else if (in_ready && !in_valid && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/conv_acc_scheduler.md
CONV_ACC_SCHEDULER -- requirements
Module: conv_acc_scheduler

Interface
REQ-001 SHALL have parameter MAC_OUT_NUM, default 18, output channels driven by the MAC core (width of the adder_rst vector).
REQ-002 SHALL have parameter MAC_IN_NUM, default 9, input lanes per beat.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, bits per input lane.
REQ-004 SHALL have parameter PIX_CNT_WIDTH, default 16, width of the pixel counters.
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port rstn  in  1  asynchronous active-low reset.
REQ-007 SHALL have port start  in  1  job start pulse, honoured only in IDLE.
REQ-008 SHALL have port abort  in  1  synchronous job cancel.
REQ-009 SHALL have port cfg_acc_num  in  8  beats accumulated per output pixel.
REQ-010 SHALL have port cfg_pix_num  in  PIX_CNT_WIDTH  output pixels per job.
REQ-011 SHALL have port wt_req  out  1  weight-load request to the weight buffer.
REQ-012 SHALL have port wt_ack  in  1  single-cycle weight-buffer acknowledge.
REQ-013 SHALL have port in_data  in  MAC_IN_NUM*DATA_WIDTH  feature beat.
REQ-014 SHALL have ports in_valid  in  1  and in_ready  out  1  as the feature handshake.
REQ-015 SHALL have port mac_data  out  MAC_IN_NUM*DATA_WIDTH  registered beat to the core.
REQ-016 SHALL have ports mac_data_valid  out  1  and mac_weight_valid  out  1  as core strobes.
REQ-017 SHALL have port adder_rst  out  MAC_OUT_NUM  accumulator clear, one bit per output channel.
REQ-018 SHALL have port mac_out_valid  in  1  core result strobe.
REQ-019 SHALL have ports busy  out  1  and done  out  1  (single-cycle pulse).

Function
REQ-020 SHALL implement states IDLE, LOAD_W, RUN, DRAIN, DONE.
REQ-021 SHALL, on start in IDLE, latch cfg_acc_num (0 treated as 1) and cfg_pix_num, then enter LOAD_W; start outside IDLE is ignored.
REQ-022 SHALL, if latched cfg_pix_num is 0, go IDLE->DONE directly, with no wt_req and no beats.
REQ-023 SHALL hold wt_req high throughout LOAD_W; on wt_ack, drive mac_weight_valid high for exactly the next cycle and enter RUN that same next cycle.
REQ-024 SHALL assert in_ready only in RUN while accepted beats < acc_num*pix_num.
REQ-025 SHALL, per accepted beat (in_valid&in_ready), register in_data to mac_data and pulse mac_data_valid one cycle later (latency 1).
REQ-026 SHALL drive adder_rst all-ones in the same cycle as mac_data_valid for the first beat of each pixel (beat counter 0), else all-zeros.
REQ-027 SHALL wrap the beat counter from acc_num-1 to 0 and increment the pixel counter on that wrap.
REQ-028 SHALL enter DRAIN on acceptance of the final beat of the final pixel.
REQ-029 SHALL count mac_out_valid pulses in all non-IDLE states; leave DRAIN for DONE when the count equals pix_num.
REQ-030 SHALL pulse done for one cycle in DONE, then return to IDLE; busy high in every state except IDLE.
REQ-031 SHALL, on abort in any state, force IDLE next cycle, clear counters, drop in_ready/wt_req/strobes, and emit no done.
REQ-032 SHALL give abort priority over start, wt_ack and in_valid in the same cycle.

Reset
REQ-033 SHALL, on rstn low, asynchronously set state IDLE, all counters 0, and every output 0 (including mac_data and adder_rst).
REQ-034 SHALL, on reset mid-job, discard the job completely; no done after release.

Configuration
REQ-035 SHALL, with CONV_SCHED_PERF_CNT_EN defined, add output stall_cnt (32 bits) counting RUN cycles with in_ready&!in_valid, cleared on start, saturating at all-ones.
REQ-036 SHALL, without CONV_SCHED_PERF_CNT_EN, omit stall_cnt port and logic entirely; all other behaviour identical.

Verification
REQ-037 SHALL cover: acc_num=3, pix_num=2, in_valid constant -> wt_req until ack, mac_weight_valid 1 cycle, 6 beats, adder_rst pulses on beats 0 and 3, done after 2nd mac_out_valid.
REQ-038 SHALL cover: pix_num=0 -> no wt_req, done 1 cycle after start, busy high for 1 cycle.
REQ-039 SHALL cover: acc_num=0, pix_num=4 -> behaves as acc_num=1, adder_rst on every one of 4 beats.
REQ-040 SHALL cover: in_valid toggled 1/0 with CONV_SCHED_PERF_CNT_EN, acc_num=2, pix_num=2 -> stall_cnt = 3, done still asserted once.
REQ-041 SHALL cover: abort on 2nd beat with start same cycle -> IDLE next cycle, in_ready 0, no done; new start then completes normally.
REQ-042 SHALL cover: rstn low during DRAIN -> all outputs 0 immediately, busy 0 after release.
